// File: rtl/axis_sample_tx.sv
// axis_sample_tx: buffers DSP sample words in a small first-word-fall-through
// FIFO and presents them as an AXI4-Stream master with framed tlast, a
// handshake counter and a sticky overflow flag.
//
// Ports:
//   clk, reset           single clock (rising edge), async active-high reset
//   din, din_valid       sample word in; dropped if offered while full
//   din_ready            FIFO not full (state only, no path from tready)
//   framelen             beats per frame, 0 = never assert tlast
//   clr_stat             strobe clearing cnt and ovf (wins over updates)
//   tdata/tvalid/tready/tlast  AXI4-Stream master side
//   cnt                  completed handshakes, wraps modulo 2^CNTWIDTH
//   ovf                  sticky: din_valid seen while full
//   level                FIFO occupancy, 0..DEPTH
module axis_sample_tx #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 4,
  parameter int CNTWIDTH   = 32,
  parameter int FLWIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic [FLWIDTH-1:0]       framelen,
  input  logic                     clr_stat,
  output logic [DATA_WIDTH-1:0]    tdata,
  output logic                     tvalid,
  input  logic                     tready,
  output logic                     tlast,
  output logic [CNTWIDTH-1:0]      cnt,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  rdy_q, rdy_d;
  logic [CNTWIDTH-1:0]   cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [FLWIDTH-1:0]    beat_q, beat_d;
  logic [FLWIDTH-1:0]    fl_q, fl_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic full, push, pop;

  // rdy_q holds din_ready low through reset and releases it on the first
  // edge afterwards, independent of the (empty) occupancy.
  assign full      = (level_q == FULL_LVL);
  assign din_ready = rdy_q && !full;
  assign tvalid    = (level_q != '0);
  assign push      = din_valid && din_ready;
  assign pop       = tvalid && tready;
  assign tdata     = mem_q[rptr_q];
  // Uses the latched length only, so tlast cannot move while a beat stalls.
  assign tlast     = tvalid && (fl_q != '0) && (beat_q == fl_q - FLWIDTH'(1));
  assign cnt       = cnt_q;
  assign ovf       = ovf_q;
  assign level     = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    rdy_d   = 1'b1;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    beat_d  = beat_q;
    fl_d    = fl_q;

    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (clr_stat) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (pop)                cnt_d = cnt_q + CNTWIDTH'(1);
      if (din_valid && full)  ovf_d = 1'b1;
    end

    // Frame length is picked up only at a frame boundary: on the pop that
    // closes a frame, or while idle at beat 0. With length 0 there are no
    // frames, so the beat stays at 0 and a new length is taken on any pop.
    if (pop) begin
      if (fl_q == '0 || tlast) begin
        beat_d = '0;
        fl_d   = framelen;
      end else begin
        beat_d = beat_q + FLWIDTH'(1);
      end
    end else if (beat_q == '0 && !tvalid) begin
      fl_d = framelen;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      beat_q  <= '0;
      fl_q    <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      beat_q  <= beat_d;
      fl_q    <= fl_d;
    end
  end

  // Storage needs no reset: contents are only visible while level != 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end

endmodule

// File: tb/tb_axis_sample_tx.sv
// Bench for axis_sample_tx: a table of directed vectors for the fill/drain
// corner, a queue scoreboard checking every cycle, and hand-written sequences
// for framing, reset and counter corners.
module tb_axis_sample_tx;
  localparam int DW = 16, DEPTH = 4, CW = 8, FLW = 8;
  localparam int LW = $clog2(DEPTH) + 1;

  logic           clk = 1'b0, reset = 1'b0;
  logic [DW-1:0]  din = '0;
  logic           din_valid = 1'b0, clr_stat = 1'b0, tready = 1'b0;
  logic [FLW-1:0] framelen = '0;
  logic           din_ready, tvalid, tlast, ovf;
  logic [DW-1:0]  tdata;
  logic [CW-1:0]  cnt;
  logic [LW-1:0]  level;

  axis_sample_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNTWIDTH(CW), .FLWIDTH(FLW)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .framelen(framelen), .clr_stat(clr_stat), .tdata(tdata), .tvalid(tvalid),
    .tready(tready), .tlast(tlast), .cnt(cnt), .ovf(ovf), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk = 0, n_fail = 0;

  // reference model state
  logic [DW-1:0] q[$];
  bit            tlast_log[$];
  logic [CW-1:0] cnt_m = '0;
  bit            ovf_m = 1'b0, rdy_m = 1'b0, stall_p = 1'b0, tlast_p = 1'b0;
  logic [DW-1:0] tdata_p = '0;

  typedef struct {
    logic dv; logic [DW-1:0] d; logic tr; logic clr;
    logic [LW-1:0] lvl; logic rdy; logic tv; logic [DW-1:0] td; logic ov; logic [CW-1:0] c;
  } vec_t;
  vec_t tbl[12];

  bit exp_f3[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  bit exp_chg[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  bit exp_f4[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  function automatic vec_t mk(int dv, int d, int tr, int clr, int lvl, int rdy, int tv,
                              int td, int ov, int c);
    vec_t v;
    v.dv = 1'(dv); v.d = DW'(d); v.tr = 1'(tr); v.clr = 1'(clr);
    v.lvl = LW'(lvl); v.rdy = 1'(rdy); v.tv = 1'(tv); v.td = DW'(td); v.ov = 1'(ov);
    v.c = CW'(c);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard step, run mid-cycle while inputs and state are stable.
  task automatic mon();
    int sz; bit pop, push; logic [DW-1:0] e;
    sz = q.size();
    chk("level",     64'(level),     64'(sz));
    chk("tvalid",    64'(tvalid),    64'(sz != 0));
    chk("din_ready", 64'(din_ready), 64'(rdy_m && sz != DEPTH));
    chk("cnt",       64'(cnt),       64'(cnt_m));
    chk("ovf",       64'(ovf),       64'(ovf_m));
    if (stall_p && tvalid) begin
      chk("tdata_stable", 64'(tdata), 64'(tdata_p));
      chk("tlast_stable", 64'(tlast), 64'(tlast_p));
    end
    if (!reset) begin
      pop  = (sz != 0) && tready;
      push = din_valid && rdy_m && (sz != DEPTH);
      if (pop) begin
        e = q.pop_front();
        chk("tdata", 64'(tdata), 64'(e));
        tlast_log.push_back(tlast);
      end
      if (push) q.push_back(din);
      if (clr_stat) begin
        cnt_m = '0; ovf_m = 1'b0;
      end else begin
        if (pop) cnt_m = cnt_m + CW'(1);
        if (din_valid && sz == DEPTH) ovf_m = 1'b1;
      end
      stall_p = (sz != 0) && !tready;
      tdata_p = tdata;
      tlast_p = tlast;
    end else begin
      stall_p = 1'b0;
    end
  endtask

  // One clock: scoreboard at the falling edge, return 1 time unit after rising.
  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    rdy_m = !reset;
  endtask

  task automatic do_reset();
    reset = 1'b1; din_valid = 1'b0; tready = 1'b0; clr_stat = 1'b0;
    #1;
    q.delete(); rdy_m = 1'b0; cnt_m = '0; ovf_m = 1'b0; stall_p = 1'b0;
    chk("rst_tvalid",    64'(tvalid),    64'd0);
    chk("rst_tlast",     64'(tlast),     64'd0);
    chk("rst_din_ready", 64'(din_ready), 64'd0);
    chk("rst_level",     64'(level),     64'd0);
    chk("rst_cnt",       64'(cnt),       64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    step(); step();
    reset = 1'b0;
    chk("din_ready_before_edge", 64'(din_ready), 64'd0);
    step();
    chk("din_ready_first_edge", 64'(din_ready), 64'd1);
  endtask

  task automatic run_stream(input int n, input bit tog, input bit rnd, input int chg_at,
                            input logic [FLW-1:0] new_fl);
    int sent, guard;
    sent = 0; guard = 0;
    do begin
      if (sent < n) begin
        din_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        din = DW'($urandom);
      end else begin
        din_valid = 1'b0;
      end
      tready = tog ? ~tready : 1'b1;
      if (chg_at >= 0 && tlast_log.size() == chg_at) framelen = new_fl;
      if (din_valid && rdy_m && q.size() != DEPTH) sent++;
      step();
      guard++;
    end while ((sent < n || q.size() != 0) && guard < 4000);
    chk("stream_leftover", 64'((n - sent) + q.size()), 64'd0);
    din_valid = 1'b0;
    tready = 1'b0;
  endtask

  initial begin
    int base;
    tbl[0]  = mk(1, 1, 0, 0,  0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 2, 0, 0,  1, 1, 1, 1, 0, 0);
    tbl[2]  = mk(1, 3, 0, 0,  2, 1, 1, 1, 0, 0);
    tbl[3]  = mk(1, 4, 0, 0,  3, 1, 1, 1, 0, 0);
    tbl[4]  = mk(1, 5, 0, 0,  4, 0, 1, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,  4, 0, 1, 1, 1, 0);
    tbl[6]  = mk(1, 6, 1, 0,  4, 0, 1, 1, 1, 0);
    tbl[7]  = mk(0, 0, 1, 0,  3, 1, 1, 2, 1, 1);
    tbl[8]  = mk(0, 0, 1, 0,  2, 1, 1, 3, 1, 2);
    tbl[9]  = mk(0, 0, 1, 0,  1, 1, 1, 4, 1, 3);
    tbl[10] = mk(0, 0, 0, 1,  0, 1, 0, 0, 1, 4);
    tbl[11] = mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0);

    #2;
    do_reset();

    // fill past full, pop while full with din offered, drain, clear stats
    for (int i = 0; i < 12; i++) begin
      din_valid = tbl[i].dv; din = tbl[i].d; tready = tbl[i].tr; clr_stat = tbl[i].clr;
      chk($sformatf("v%0d_level", i),     64'(level),     64'(tbl[i].lvl));
      chk($sformatf("v%0d_din_ready", i), 64'(din_ready), 64'(tbl[i].rdy));
      chk($sformatf("v%0d_tvalid", i),    64'(tvalid),    64'(tbl[i].tv));
      if (tbl[i].tv) chk($sformatf("v%0d_tdata", i), 64'(tdata), 64'(tbl[i].td));
      chk($sformatf("v%0d_ovf", i),       64'(ovf),       64'(tbl[i].ov));
      chk($sformatf("v%0d_cnt", i),       64'(cnt),       64'(tbl[i].c));
      step();
    end
    clr_stat = 1'b0;

    // framelen 3, continuous stream of 7
    framelen = FLW'(3);
    base = tlast_log.size();
    run_stream(7, 1'b0, 1'b0, -1, '0);
    chk("f3_beats", 64'(tlast_log.size() - base), 64'd7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("f3_tlast_beat%0d", i + 1), 64'(tlast_log[base + i]), 64'(exp_f3[i]));
    chk("stream_ovf", 64'(ovf), 64'd0);

    // framelen 3 -> 2 while beat 2 is presented
    do_reset();
    framelen = FLW'(3);
    base = tlast_log.size();
    run_stream(7, 1'b0, 1'b0, base + 1, FLW'(2));
    chk("chg_beats", 64'(tlast_log.size() - base), 64'd7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("chg_tlast_beat%0d", i + 1), 64'(tlast_log[base + i]), 64'(exp_chg[i]));

    // reset mid-frame with three words buffered
    framelen = FLW'(4);
    din_valid = 1'b1; tready = 1'b0;
    repeat (4) begin din = DW'($urandom); step(); end
    din_valid = 1'b0; tready = 1'b1;
    step();
    tready = 1'b0;
    chk("midframe_level", 64'(level), 64'd3);
    do_reset();
    din = 16'h00A5; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk("post_rst_tdata", 64'(tdata), 64'h00A5);
    chk("post_rst_tlast", 64'(tlast), 64'd0);
    base = tlast_log.size();
    run_stream(3, 1'b0, 1'b0, -1, '0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("post_rst_tlast_beat%0d", i + 1), 64'(tlast_log[base + i]), 64'(exp_f4[i]));

    // tready toggling, random din_valid
    framelen = FLW'(5);
    run_stream(60, 1'b1, 1'b1, -1, '0);

    // counter wrap
    do_reset();
    framelen = '0;
    run_stream(255, 1'b0, 1'b0, -1, '0);
    chk("cnt_max", 64'(cnt), 64'd255);
    run_stream(1, 1'b0, 1'b0, -1, '0);
    chk("cnt_wrap", 64'(cnt), 64'd0);

    // clr_stat coincident with a pop
    din_valid = 1'b1;
    din = DW'($urandom); step();
    din = DW'($urandom); step();
    din_valid = 1'b0; tready = 1'b1;
    step();
    chk("cnt_before_clr", 64'(cnt), 64'd1);
    clr_stat = 1'b1;
    step();
    clr_stat = 1'b0; tready = 1'b0;
    chk("cnt_clr_pop", 64'(cnt), 64'd0);
    chk("level_clr_pop", 64'(level), 64'd0);

    // clr_stat coincident with an overflow
    din_valid = 1'b1;
    repeat (4) begin din = DW'($urandom); step(); end
    chk("full_level", 64'(level), 64'd4);
    clr_stat = 1'b1;
    step();
    clr_stat = 1'b0;
    chk("ovf_clr_wins", 64'(ovf), 64'd0);
    step();
    chk("ovf_set", 64'(ovf), 64'd1);
    din_valid = 1'b0; tready = 1'b1;
    repeat (4) step();
    tready = 1'b0;
    chk("drained_level", 64'(level), 64'd0);
    chk("drained_cnt", 64'(cnt), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
